color_convert_ycc_sum: RTL
==========================

# color_convert_ycc_sum

Streaming accumulate/round/clamp stage directly downstream of the colour-convert coefficient multiplier. It consumes the unsigned 24-bit products (pixel × Q8 coefficient) one per handshake, nine per pixel in fixed order. It sums each group of three with a fixed sign pattern, then rounds, offsets and saturates each sum to 8 bits. It emits one packed {Y, Cb, Cr} pixel to the JPEG block-buffer stage over a valid/ready interface.

## Interface
- PROD_WIDTH, 24, width of one multiplier product (unsigned)
- ACC_WIDTH, 27, signed accumulator width (PROD_WIDTH + 3)
- FRAC_BITS, 8, fractional bits of the coefficients (Q8)
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous resync: restarts the term sequence at term 0
- prod_din  in  PROD_WIDTH  product for the current term
- prod_valid  in  1  prod_din valid
- prod_ready  out  1  stage accepts prod_din this cycle
- ycc_dout  out  24  {Y[23:16], Cb[15:8], Cr[7:0]}
- ycc_valid  out  1  ycc_dout valid
- ycc_ready  in  1  downstream accepts ycc_dout

## Operation
- Term order per pixel, index t = 0..8: Y(R,G,B), Cb(R,G,B), Cr(R,G,B). Component c = t/3.
- Sign table (+ add, − subtract): Y +,+,+; Cb −,−,+; Cr +,−,−. Offsets: Y 0, Cb 128, Cr 128.
- Accept occurs when prod_valid & prod_ready. On accept at t%3==0, acc loads ±prod. Otherwise acc = acc ± prod. Products are zero-extended to ACC_WIDTH before the sign is applied.
- Component finalisation on its third term (t = 2, 5, 8): r = ((sum + 2^(FRAC_BITS−1)) >>> FRAC_BITS) + offset, arithmetic shift. Clamp r to [0,255].
  - Y and Cb are stored in y_reg and cb_reg.
  - At t = 8, the output register loads {y_reg, cb_reg, Cr}, ycc_valid is set, and t wraps to 0.
- Term counter t: 0..8, increments on each accept, wraps 8→0.
- prod_ready = !ap_rst & !clear & !(t==8 & ycc_valid & !ycc_ready). Terms 0–7 of the next pixel are accepted while an output is pending. Only the completing term stalls.
- ycc_valid clears on ycc_valid & ycc_ready unless a new pixel completes in the same cycle, in which case it stays high with the new data.
- clear: t←0 and acc←0. Any product presented in the same cycle is not accepted. A pending output register is unaffected.
- ap_rst: t=0, acc=0, y_reg=cb_reg=0, ycc_dout=0, ycc_valid=0. prod_ready is 0 during reset and 1 in the first cycle after reset.

## Timing
- Latency: ycc_valid is high in the cycle after the 9th term is accepted.
- Throughput: 1 product/cycle sustained, so 1 pixel per 9 cycles, with ycc_ready held high.
- ycc_dout and ycc_valid are registered. prod_ready is combinational from ycc_ready, t and ycc_valid, with no path from prod_valid.
- ycc_dout is stable while ycc_valid & !ycc_ready.
- Reset or clear mid-pixel discards the partial pixel. Reset also drops a pending output.

## Structure
- Package color_convert_pkg holds:
  - PROD_WIDTH, ACC_WIDTH and FRAC_BITS defaults.
  - The 9-entry sign table TERM_SUB[0:8] = {0,0,0, 1,1,0, 0,1,1}.
  - The component offset constants {0,128,128}.
  - The term-index type (4 bits).
- Sub-module color_convert_ycc_round_clamp is combinational: signed sum + offset in, 8-bit saturated value out. It is instantiated once and shared across components.

## Test plan
- R=G=B=255, products {65280×... per coeff}: Y terms 19635,38250,7395; Cb 10965,21675,32640; Cr 32640,27285,5355 → ycc_dout 0xFF8080 one cycle after term 9.
- Pure red: Y 19635,0,0; Cb 10965,0,0; Cr 32640,0,0 → Y=77, Cb=85, Cr=255 (saturated), i.e. 0x4D55FF.
- Two pixels back-to-back with ycc_ready=0 → second pixel's term 8 sees prod_ready=0 until ycc_ready=1. First pixel is output unchanged, second follows the next cycle, no loss or duplication.
- 4 products, then clear, then a full black pixel (all 0) → exactly one output 0x008080.
- ap_rst asserted after 5 terms with an output pending → ycc_valid=0 and ycc_dout=0 next cycle. A subsequent full pixel is output correctly.
- 10 consecutive pixels, prod_valid and ycc_ready held high → ycc_valid pulses exactly every 9 cycles, with prod_ready constantly 1.

Source files
------------

// File: rtl/color_convert_ycc_sum_pkg.sv
// Shared constants and helpers for the YCbCr accumulate/round/clamp stage.
// Term order per pixel: Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
package color_convert_pkg;

  localparam int PROD_WIDTH = 24;
  localparam int ACC_WIDTH  = 27;
  localparam int FRAC_BITS  = 8;

  typedef logic [3:0] term_t;

  localparam term_t TERM_FIRST = 4'd0;
  localparam term_t TERM_LAST  = 4'd8;

  // A 1 bit means the product is subtracted for that term index.
  localparam logic [0:8] TERM_SUB = 9'b000_110_011;

  localparam logic [8:0] OFFSET_Y  = 9'd0;
  localparam logic [8:0] OFFSET_CB = 9'd128;
  localparam logic [8:0] OFFSET_CR = 9'd128;

  function automatic logic [1:0] term_comp(input term_t t);
    if (t < 4'd3)      return 2'd0;
    else if (t < 4'd6) return 2'd1;
    else               return 2'd2;
  endfunction

  function automatic logic term_first(input term_t t);
    return (t == 4'd0) || (t == 4'd3) || (t == 4'd6);
  endfunction

  function automatic logic [8:0] comp_offset(input logic [1:0] c);
    case (c)
      2'd0:    return OFFSET_Y;
      2'd1:    return OFFSET_CB;
      default: return OFFSET_CR;
    endcase
  endfunction

endpackage

// File: rtl/color_convert_ycc_sum_if.sv
// Product input and packed YCbCr output handshakes of the accumulate stage.
// valid/ready: a word transfers on a rising edge where both are high; a source holds its word until then.
import color_convert_pkg::*;

interface color_convert_ycc_sum_if #(
  parameter int PW = PROD_WIDTH
);
  logic [PW-1:0] prod_din;
  logic          prod_valid;
  logic          prod_ready;
  logic [23:0]   ycc_dout;
  logic          ycc_valid;
  logic          ycc_ready;

  modport master (
    output prod_din, prod_valid, ycc_ready,
    input  prod_ready, ycc_dout, ycc_valid
  );

  modport slave (
    input  prod_din, prod_valid, ycc_ready,
    output prod_ready, ycc_dout, ycc_valid
  );
endinterface

// File: rtl/color_convert_ycc_sum_round_clamp.sv
// Rounds a Q8 signed sum to an integer, adds the component offset and
// saturates the result to an unsigned byte.
import color_convert_pkg::*;

module color_convert_ycc_round_clamp #(
  parameter int AW = ACC_WIDTH,
  parameter int FB = FRAC_BITS
) (
  input  logic signed [AW-1:0] sum,
  input  logic        [8:0]    offset,
  output logic        [7:0]    val
);
  localparam logic signed [AW:0] RND = (AW+1)'(2 ** (FB - 1));

  logic signed [AW:0] biased;
  logic signed [AW:0] shifted;
  logic signed [AW:0] r;

  always_comb begin
    // One extra bit of headroom so the rounding bias cannot wrap.
    biased  = {sum[AW-1], sum} + RND;
    shifted = biased >>> FB;
    r       = shifted + (AW+1)'(offset);
    if (r < 0)
      val = 8'd0;
    else if (r > 255)
      val = 8'd255;
    else
      val = r[7:0];
  end
endmodule

// File: rtl/color_convert_ycc_sum.sv
// Accumulates nine multiplier products per pixel into Y, Cb, Cr with fixed
// signs, rounds/offsets/clamps each to 8 bits and emits one packed pixel.
import color_convert_pkg::*;

module color_convert_ycc_sum #(
  parameter int PW = PROD_WIDTH,
  parameter int AW = ACC_WIDTH,
  parameter int FB = FRAC_BITS
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       clear,
  color_convert_ycc_sum_if.slave     bus,
  output term_t                      dbg_term
);
  term_t               t;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] term_val;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] sum_next;
  logic        [7:0]    comp_val;
  logic        [7:0]    y_reg;
  logic        [7:0]    cb_reg;
  logic        [23:0]   out_data;
  logic                 out_valid;
  logic                 accept;

  // Only the completing term stalls behind an unaccepted output.
  assign bus.prod_ready = !ap_rst && !clear &&
                          !((t == TERM_LAST) && out_valid && !bus.ycc_ready);
  assign accept        = bus.prod_valid && bus.prod_ready;
  assign bus.ycc_dout  = out_data;
  assign bus.ycc_valid = out_valid;
  assign dbg_term      = t;

  always_comb begin
    ext      = {{(AW-PW){1'b0}}, bus.prod_din};
    term_val = TERM_SUB[t] ? -ext : ext;
    base     = term_first(t) ? '0 : acc;
    sum_next = base + term_val;
  end

  color_convert_ycc_round_clamp #(
    .AW (AW),
    .FB (FB)
  ) u_round_clamp (
    .sum    (sum_next),
    .offset (comp_offset(term_comp(t))),
    .val    (comp_val)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      t         <= TERM_FIRST;
      acc       <= '0;
      y_reg     <= '0;
      cb_reg    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && bus.ycc_ready)
        out_valid <= 1'b0;
      if (clear) begin
        t   <= TERM_FIRST;
        acc <= '0;
      end else if (accept) begin
        acc <= sum_next;
        t   <= (t == TERM_LAST) ? TERM_FIRST : t + 4'd1;
        // A pixel completing on a draining cycle overrides the clear above.
        case (t)
          4'd2:      y_reg  <= comp_val;
          4'd5:      cb_reg <= comp_val;
          TERM_LAST: begin
            out_data  <= {y_reg, cb_reg, comp_val};
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
